// File: rtl/rl_step_scheduler.sv
// ---------------------------------------------------------------------------
// rl_step_scheduler
//
// Sequences a single Q-learning agent through whole episodes, one step at a
// time: read the Q-row of the current state, let the policy generator pick an
// action, hand that action to the environment, collect the environment's
// response and finally issue one Q-update request. Also keeps the
// per-episode step count, the episode count and the exploration epsilon.
//
// Optional feature macro: RL_EPS_DECAY_EN
//   defined   : epsilon decays by EPS_DECAY at each episode end, floored at
//               EPS_MIN (no underflow).
//   undefined : epsilon is the constant EPS_INIT; no decay logic exists.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   run                 level request to keep running episodes
//   start_state         initial state, sampled when an episode begins
//   q_rd/q_addr         one-cycle Q-row read strobe and row address
//   q_rvalid/q_data     Q-row return (four 16-bit Q values)
//   q_row               registered Q-row handed to the policy generator
//   sel_start           one-cycle start pulse to the policy generator
//   sel_action          action chosen by the policy generator
//   epsilon             current exploration rate
//   act_valid/act/act_ready               action handshake to environment
//   env_valid/env_next_state/env_reward/env_terminal  environment result
//   upd_valid/upd_state/upd_action/upd_next_state/upd_reward/upd_ready
//                       Q-update request handshake
//   busy                high whenever an episode is in progress
//   episode_done        one-cycle pulse at episode end
//   step_cnt            steps completed in the current episode (saturating)
//   episode_cnt         episodes completed (wrapping)
// ---------------------------------------------------------------------------
module rl_step_scheduler #(
  parameter int          STATE_W   = 4,
  parameter int          SEL_LAT   = 1,
  parameter int          MAX_STEPS = 64,
  parameter logic [15:0] EPS_INIT  = 16'hFFFF,
  parameter logic [15:0] EPS_MIN   = 16'h0CCC,
  parameter logic [15:0] EPS_DECAY = 16'h0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [STATE_W-1:0] start_state,
  output logic               q_rd,
  output logic [STATE_W-1:0] q_addr,
  input  logic               q_rvalid,
  input  logic [63:0]        q_data,
  output logic [63:0]        q_row,
  output logic               sel_start,
  input  logic [3:0]         sel_action,
  output logic [15:0]        epsilon,
  output logic               act_valid,
  output logic [3:0]         act,
  input  logic               act_ready,
  input  logic               env_valid,
  input  logic [STATE_W-1:0] env_next_state,
  input  logic [15:0]        env_reward,
  input  logic               env_terminal,
  output logic               upd_valid,
  output logic [STATE_W-1:0] upd_state,
  output logic [3:0]         upd_action,
  output logic [STATE_W-1:0] upd_next_state,
  output logic [15:0]        upd_reward,
  input  logic               upd_ready,
  output logic               busy,
  output logic               episode_done,
  output logic [15:0]        step_cnt,
  output logic [15:0]        episode_cnt
);

  // Elaboration-time parameter sanity checks.
  if (SEL_LAT < 1 || SEL_LAT > 15) begin : g_bad_sel_lat
    $error("rl_step_scheduler: SEL_LAT must be in 1..15");
  end
  if (MAX_STEPS < 1 || MAX_STEPS > 65535) begin : g_bad_max_steps
    $error("rl_step_scheduler: MAX_STEPS must be in 1..65535");
  end
  if (({1'b0, EPS_MIN} + {1'b0, EPS_DECAY}) > 17'h0FFFF || EPS_MIN > EPS_INIT) begin : g_bad_eps
    $error("rl_step_scheduler: inconsistent epsilon parameters");
  end

  localparam logic [3:0]  SEL_LAST    = 4'(SEL_LAT - 1);
  localparam logic [15:0] MAX_STEPS_W = 16'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SELECT,
    S_ACT,
    S_OBSERVE,
    S_UPDATE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] cur_state_q, cur_state_d;
  logic               fetch_req_q, fetch_req_d;   // q_rd not yet issued this FETCH
  logic [3:0]         sel_cnt_q, sel_cnt_d;       // cycles spent in SELECT
  logic [63:0]        q_row_q, q_row_d;
  logic [3:0]         act_q, act_d;
  logic [STATE_W-1:0] nxt_q, nxt_d;
  logic [15:0]        rew_q, rew_d;
  logic               term_q, term_d;
  logic [15:0]        step_cnt_q, step_cnt_d;
  logic [15:0]        episode_cnt_q, episode_cnt_d;
  logic [15:0]        step_inc;

`ifdef RL_EPS_DECAY_EN
  // Below this knee a full decrement would cross the floor, so clamp instead.
  localparam logic [16:0] EPS_KNEE = {1'b0, EPS_MIN} + {1'b0, EPS_DECAY};
  logic [15:0] eps_q, eps_d;
  assign epsilon = eps_q;
`else
  assign epsilon = EPS_INIT;
`endif

  // Saturating step increment; MAX_STEPS never exceeds 16'hFFFF so the limit
  // is always reached before saturation matters.
  assign step_inc = (step_cnt_q == 16'hFFFF) ? step_cnt_q : step_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    cur_state_d   = cur_state_q;
    fetch_req_d   = fetch_req_q;
    sel_cnt_d     = sel_cnt_q;
    q_row_d       = q_row_q;
    act_d         = act_q;
    nxt_d         = nxt_q;
    rew_d         = rew_q;
    term_d        = term_q;
    step_cnt_d    = step_cnt_q;
    episode_cnt_d = episode_cnt_q;
`ifdef RL_EPS_DECAY_EN
    eps_d         = eps_q;
`endif
    q_rd          = 1'b0;
    sel_start     = 1'b0;
    act_valid     = 1'b0;
    upd_valid     = 1'b0;
    episode_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d     = S_FETCH;
          cur_state_d = start_state;
          step_cnt_d  = 16'd0;
          fetch_req_d = 1'b1;
        end
      end

      S_FETCH: begin
        // Strobe only on the first FETCH cycle, then wait for the data.
        q_rd        = fetch_req_q;
        fetch_req_d = 1'b0;
        if (q_rvalid) begin
          q_row_d   = q_data;
          sel_cnt_d = 4'd0;
          state_d   = S_SELECT;
        end
      end

      S_SELECT: begin
        // SELECT lasts SEL_LAT cycles; the action is captured at the edge
        // closing the last one, SEL_LAT cycles after the start pulse began.
        sel_start = (sel_cnt_q == 4'd0);
        if (sel_cnt_q == SEL_LAST) begin
          act_d   = sel_action;
          state_d = S_ACT;
        end else begin
          sel_cnt_d = sel_cnt_q + 4'd1;
        end
      end

      S_ACT: begin
        act_valid = 1'b1;
        if (act_ready) begin
          state_d = S_OBSERVE;
        end
      end

      S_OBSERVE: begin
        if (env_valid) begin
          nxt_d   = env_next_state;
          rew_d   = env_reward;
          term_d  = env_terminal;
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        upd_valid = 1'b1;
        if (upd_ready) begin
          step_cnt_d  = step_inc;
          cur_state_d = nxt_q;
          if (term_q || step_inc == MAX_STEPS_W) begin
            state_d = S_DONE;
          end else begin
            fetch_req_d = 1'b1;
            state_d     = S_FETCH;
          end
        end
      end

      S_DONE: begin
        episode_done  = 1'b1;
        episode_cnt_d = episode_cnt_q + 16'd1;
`ifdef RL_EPS_DECAY_EN
        eps_d = ({1'b0, eps_q} < EPS_KNEE) ? EPS_MIN : eps_q - EPS_DECAY;
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_state_q   <= '0;
      fetch_req_q   <= 1'b0;
      sel_cnt_q     <= 4'd0;
      q_row_q       <= 64'd0;
      act_q         <= 4'd0;
      nxt_q         <= '0;
      rew_q         <= 16'd0;
      term_q        <= 1'b0;
      step_cnt_q    <= 16'd0;
      episode_cnt_q <= 16'd0;
`ifdef RL_EPS_DECAY_EN
      eps_q         <= EPS_INIT;
`endif
    end else begin
      state_q       <= state_d;
      cur_state_q   <= cur_state_d;
      fetch_req_q   <= fetch_req_d;
      sel_cnt_q     <= sel_cnt_d;
      q_row_q       <= q_row_d;
      act_q         <= act_d;
      nxt_q         <= nxt_d;
      rew_q         <= rew_d;
      term_q        <= term_d;
      step_cnt_q    <= step_cnt_d;
      episode_cnt_q <= episode_cnt_d;
`ifdef RL_EPS_DECAY_EN
      eps_q         <= eps_d;
`endif
    end
  end

  assign q_addr         = cur_state_q;
  assign q_row          = q_row_q;
  assign act            = act_q;
  assign upd_state      = cur_state_q;
  assign upd_action     = act_q;
  assign upd_next_state = nxt_q;
  assign upd_reward     = rew_q;
  assign busy           = (state_q != S_IDLE);
  assign step_cnt       = step_cnt_q;
  assign episode_cnt    = episode_cnt_q;

endmodule

// File: tb/tb_rl_step_scheduler.sv
// Scoreboard bench for rl_step_scheduler (SEL_LAT=1, MAX_STEPS=4).
// Stimulus pushes expected transactions; a negedge monitor pops and compares.
module tb_rl_step_scheduler;
  localparam int          STATE_W   = 4;
  localparam logic [15:0] EPS_INIT  = 16'h0300;
  localparam logic [15:0] EPS_MIN   = 16'h0180;
  localparam logic [15:0] EPS_DECAY = 16'h0100;
`ifdef RL_EPS_DECAY_EN
  localparam logic [15:0] EPS_AFTER1 = 16'h0200;
  localparam logic [15:0] EPS_AFTER2 = 16'h0180;
  localparam logic [15:0] EPS_AFTER3 = 16'h0180;
`else
  localparam logic [15:0] EPS_AFTER1 = 16'h0300;
  localparam logic [15:0] EPS_AFTER2 = 16'h0300;
  localparam logic [15:0] EPS_AFTER3 = 16'h0300;
`endif

  logic               clk, rst, run;
  logic [STATE_W-1:0] start_state;
  logic               q_rd;
  logic [STATE_W-1:0] q_addr;
  logic               q_rvalid;
  logic [63:0]        q_data, q_row;
  logic               sel_start;
  logic [3:0]         sel_action;
  logic [15:0]        epsilon;
  logic               act_valid, act_ready;
  logic [3:0]         act;
  logic               env_valid, env_terminal;
  logic [STATE_W-1:0] env_next_state;
  logic [15:0]        env_reward;
  logic               upd_valid, upd_ready;
  logic [STATE_W-1:0] upd_state, upd_next_state;
  logic [3:0]         upd_action;
  logic [15:0]        upd_reward;
  logic               busy, episode_done;
  logic [15:0]        step_cnt, episode_cnt;

  rl_step_scheduler #(
    .STATE_W(STATE_W), .SEL_LAT(1), .MAX_STEPS(4),
    .EPS_INIT(EPS_INIT), .EPS_MIN(EPS_MIN), .EPS_DECAY(EPS_DECAY)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .start_state(start_state),
    .q_rd(q_rd), .q_addr(q_addr), .q_rvalid(q_rvalid), .q_data(q_data),
    .q_row(q_row), .sel_start(sel_start), .sel_action(sel_action),
    .epsilon(epsilon), .act_valid(act_valid), .act(act), .act_ready(act_ready),
    .env_valid(env_valid), .env_next_state(env_next_state),
    .env_reward(env_reward), .env_terminal(env_terminal),
    .upd_valid(upd_valid), .upd_state(upd_state), .upd_action(upd_action),
    .upd_next_state(upd_next_state), .upd_reward(upd_reward),
    .upd_ready(upd_ready), .busy(busy), .episode_done(episode_done),
    .step_cnt(step_cnt), .episode_cnt(episode_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: next state of step k within an episode is nxt_tbl[k].
  logic [3:0] nxt_tbl [4] = '{4'd5, 4'd9, 4'd2, 4'd14};
  logic [1:0] step_idx = 2'd0;
  always @(posedge clk) begin
    if (rst || episode_done) step_idx <= 2'd0;
    else if (upd_valid && upd_ready) step_idx <= step_idx + 2'd1;
  end
  assign env_next_state = nxt_tbl[step_idx];

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  a;
    logic [15:0] r;
    logic [3:0]  nx;
  } upd_t;
  typedef struct packed {
    logic [15:0] steps;
    logic [15:0] epi;
    logic [15:0] eps;
  } done_t;

  logic [3:0] exp_addr_q [$];
  logic [3:0] exp_act_q  [$];
  upd_t       exp_upd_q  [$];
  done_t      exp_done_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced a transaction with none expected", name);
  endtask

  // Monitor: samples on the falling edge, away from input changes.
  logic       act_hold = 1'b0, upd_hold = 1'b0, done_pend = 1'b0;
  logic [3:0] act_hold_val;
  upd_t       upd_hold_val;
  done_t      done_cur;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        act_hold  = 1'b0;
        upd_hold  = 1'b0;
        done_pend = 1'b0;
      end else begin
        if (q_rd) begin
          if (exp_addr_q.size() == 0) unexpected("q_rd");
          else begin
            check("q_addr", q_addr, exp_addr_q.pop_front());
            $display("q_rd      addr=%0d", q_addr);
          end
        end
        if (act_hold) check("act_stable", {act_valid, act}, {1'b1, act_hold_val});
        act_hold     = act_valid && !act_ready;
        act_hold_val = act;
        if (act_valid && act_ready) begin
          if (exp_act_q.size() == 0) unexpected("act");
          else begin
            check("act", act, exp_act_q.pop_front());
            $display("act       a=%0d", act);
          end
        end
        if (upd_hold) check("upd_stable", {upd_valid, upd_state, upd_action, upd_reward, upd_next_state},
                            {1'b1, upd_hold_val});
        upd_hold     = upd_valid && !upd_ready;
        upd_hold_val = upd_t'{upd_state, upd_action, upd_reward, upd_next_state};
        if (upd_valid && upd_ready) begin
          if (exp_upd_q.size() == 0) unexpected("upd");
          else begin
            check("upd_tuple", upd_t'{upd_state, upd_action, upd_reward, upd_next_state},
                  exp_upd_q.pop_front());
            $display("upd       s=%0d a=%0d r=%h ns=%0d", upd_state, upd_action, upd_reward, upd_next_state);
          end
        end
        if (done_pend) begin
          check("episode_cnt", episode_cnt, done_cur.epi);
          check("epsilon", epsilon, done_cur.eps);
          $display("episode   cnt=%0d eps=%h", episode_cnt, epsilon);
          done_pend = 1'b0;
        end
        if (episode_done) begin
          if (exp_done_q.size() == 0) unexpected("episode_done");
          else begin
            done_cur = exp_done_q.pop_front();
            check("step_cnt_at_done", step_cnt, done_cur.steps);
            done_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return act_valid;
      1: return upd_valid;
      2: return episode_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input string name);
    int n = 0;
    while (!sig(which) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: still low after %0d cycles, required high", name, n);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; run = 1'b0; start_state = '0;
    q_rvalid = 1'b1; q_data = 64'd0; sel_action = 4'd0;
    act_ready = 1'b1; env_valid = 1'b1; env_reward = 16'd0;
    env_terminal = 1'b0; upd_ready = 1'b1;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_epsilon", epsilon, EPS_INIT);
    check("rst_strobes", {q_rd, sel_start, act_valid, upd_valid, episode_done}, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_episode_cnt", episode_cnt, 0);
    check("rst_q_row", q_row, 0);
    tick(); tick();
    check("idle_busy", busy, 0);

    // Single-step terminal episode, zero-wait handshakes
    q_data = 64'h0004_0003_0002_0001; start_state = 4'd3; sel_action = 4'd2;
    env_terminal = 1'b1; env_reward = 16'h0010;
    exp_addr_q.push_back(4'd3);
    exp_act_q.push_back(4'd2);
    exp_upd_q.push_back(upd_t'{4'd3, 4'd2, 16'h0010, 4'd5});
    exp_done_q.push_back(done_t'{16'd1, 16'd1, EPS_AFTER1});
    run = 1'b1;
    tick();
    run = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (episode_done) break;
      @(posedge clk);
      cyc++;
    end
    check("done_latency", cyc, 5);
    check("q_row", q_row, 64'h0004_0003_0002_0001);
    repeat (3) tick();

    // Backpressure on read data, action and update
    q_rvalid = 1'b0; act_ready = 1'b0; upd_ready = 1'b0;
    q_data = 64'hAAAA_BBBB_CCCC_DDDD; start_state = 4'd7; sel_action = 4'd9;
    env_reward = 16'hFFF0; env_terminal = 1'b1;
    exp_addr_q.push_back(4'd7);
    exp_act_q.push_back(4'd9);
    exp_upd_q.push_back(upd_t'{4'd7, 4'd9, 16'hFFF0, 4'd5});
    exp_done_q.push_back(done_t'{16'd1, 16'd2, EPS_AFTER2});
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick();
    q_rvalid = 1'b1;
    wait_until(0, "act_valid");
    tick(); tick();
    act_ready = 1'b1;
    wait_until(1, "upd_valid");
    tick();
    upd_ready = 1'b1;
    wait_until(2, "episode_done");
    check("bp_q_row", q_row, 64'hAAAA_BBBB_CCCC_DDDD);
    repeat (3) tick();

    // Step limit: four non-terminal steps chaining next_state
    start_state = 4'd1; sel_action = 4'd4; env_reward = 16'h0020; env_terminal = 1'b0;
    exp_addr_q.push_back(4'd1); exp_addr_q.push_back(4'd5);
    exp_addr_q.push_back(4'd9); exp_addr_q.push_back(4'd2);
    for (int i = 0; i < 4; i++) exp_act_q.push_back(4'd4);
    exp_upd_q.push_back(upd_t'{4'd1, 4'd4, 16'h0020, 4'd5});
    exp_upd_q.push_back(upd_t'{4'd5, 4'd4, 16'h0020, 4'd9});
    exp_upd_q.push_back(upd_t'{4'd9, 4'd4, 16'h0020, 4'd2});
    exp_upd_q.push_back(upd_t'{4'd2, 4'd4, 16'h0020, 4'd14});
    exp_done_q.push_back(done_t'{16'd4, 16'd3, EPS_AFTER3});
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_until(2, "episode_done");
    repeat (3) tick();
    check("limit_busy", busy, 0);
    check("limit_step_cnt", step_cnt, 4);
    check("limit_cur_state", q_addr, 4'd14);

    // Reset while UPDATE is stalled
    upd_ready = 1'b0; start_state = 4'd6;
    exp_addr_q.push_back(4'd6);
    exp_act_q.push_back(4'd4);
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_until(1, "upd_valid");
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_upd_valid", upd_valid, 0);
    check("mid_rst_step_cnt", step_cnt, 0);
    check("mid_rst_episode_done", episode_done, 0);
    check("mid_rst_episode_cnt", episode_cnt, 0);
    check("mid_rst_epsilon", epsilon, EPS_INIT);
    rst = 1'b0; upd_ready = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", busy, 0);

    check("addr_q_left", exp_addr_q.size(), 0);
    check("act_q_left", exp_act_q.size(), 0);
    check("upd_q_left", exp_upd_q.size(), 0);
    check("done_q_left", exp_done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rl_step_scheduler.md
Name: rl_step_scheduler

Overview:
- Sequences one Q-learning agent step by step over whole episodes.
- Each step: fetch the Q-row for the current state, start the policy generator, hand the chosen action to the environment, collect next state and reward, then issue one Q-update request.
- Owns per-episode epsilon and step/episode bookkeeping.
- Sits between the Q-table memory, the policy generator, the environment interface and the Q-update datapath.

Parameters:
- STATE_W, 4, state index width (up to 16 states).
- SEL_LAT, 1, cycles from sel_start to a valid sel_action (min 1, max 15).
- MAX_STEPS, 64, step limit per episode (1..65535).
- EPS_INIT, 16'hFFFF, epsilon loaded at reset.
- EPS_MIN, 16'h0CCC, epsilon floor.
- EPS_DECAY, 16'h0100, epsilon decrement per completed episode.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; while high, the block begins a new episode when idle.
- start_state  in  STATE_W  initial state, sampled on IDLE->FETCH.
- q_rd  out  1  one-cycle Q-row read strobe.
- q_addr  out  STATE_W  Q-row address (current state).
- q_rvalid  in  1  Q-row data valid.
- q_data  in  64  four 16-bit Q values.
- q_row  out  64  registered Q-row to the policy generator.
- sel_start  out  1  one-cycle start pulse to the policy generator.
- sel_action  in  4  action from the policy generator.
- epsilon  out  16  current epsilon to the policy generator.
- act_valid  out  1  action offered to the environment.
- act  out  4  action value.
- act_ready  in  1  environment accepts the action.
- env_valid  in  1  environment result valid.
- env_next_state  in  STATE_W  resulting state.
- env_reward  in  16  signed reward.
- env_terminal  in  1  terminal-state flag.
- upd_valid  out  1  Q-update request.
- upd_state, upd_action, upd_next_state, upd_reward  out  STATE_W/4/STATE_W/16  update tuple.
- upd_ready  in  1  update accepted.
- busy  out  1  high in any non-IDLE state.
- episode_done  out  1  one-cycle pulse at episode end.
- step_cnt  out  16  steps completed in the current episode.
- episode_cnt  out  16  episodes completed, wraps at 16'hFFFF->0.

Behaviour:
- Reset: all outputs 0 except epsilon=EPS_INIT; state IDLE. rst has priority in every state; an in-flight step is abandoned and no handshake completes.
- IDLE:
  - run=1 -> FETCH; cur_state<=start_state; step_cnt<=0.
- FETCH:
  - q_rd pulses on the first cycle only, with q_addr=cur_state.
  - Waits for q_rvalid, then q_row<=q_data -> SELECT.
- SELECT:
  - sel_start pulses on the first cycle.
  - sel_action is sampled exactly SEL_LAT cycles after the pulse into act_r -> ACT.
- ACT:
  - act_valid=1, act=act_r, both held stable until act_ready.
  - Transfer occurs on the cycle with act_valid&act_ready -> OBSERVE.
- OBSERVE:
  - Waits for env_valid, then latches next_state, reward and terminal -> UPDATE.
  - env_valid outside OBSERVE is ignored.
- UPDATE:
  - upd_valid=1 with tuple (cur_state, act_r, reward, next_state), all held until upd_ready.
  - On transfer: step_cnt+1 (saturating); cur_state<=next_state.
  - If terminal or step_cnt+1==MAX_STEPS -> DONE, else -> FETCH.
  - terminal and limit reached in the same step count as one episode end.
- DONE (1 cycle):
  - episode_done=1; episode_cnt+1; epsilon update (see Optional Feature) -> IDLE.
  - A new episode starts the following cycle if run is still high.
- run deasserted mid-episode: no effect; the episode completes.
- Latency of a step with zero-wait handshakes (q_rvalid, act_ready, env_valid, upd_ready all 1): 4+SEL_LAT cycles (FETCH 1, SELECT SEL_LAT, ACT 1, OBSERVE 1, UPDATE 1).

Optional Feature:
- RL_EPS_DECAY_EN defined: in DONE, epsilon<=max(epsilon-EPS_DECAY, EPS_MIN), computed without underflow (if epsilon<EPS_MIN+EPS_DECAY, the result is EPS_MIN).
- Not defined: epsilon stays at EPS_INIT permanently and there is no decay logic.

Test Plan:
- Reset then idle: rst 2 cycles, run=0 -> busy=0, epsilon=16'hFFFF, all strobes 0, counters 0.
- Single-step terminal episode: start_state=3, all ready/valid tied 1, sel_action=2, env_terminal=1, reward=16'h0010 -> q_addr=3 and q_rd pulse, upd tuple (3,2,16'h0010,next), episode_done 5 cycles after run (SEL_LAT=1), episode_cnt=1.
- Backpressure: act_ready low 3 cycles, upd_ready low 2 cycles -> act/upd fields stable throughout, exactly one transfer each, step_cnt=1.
- Step limit: MAX_STEPS=4, env_terminal=0 -> exactly 4 upd transfers, cur_state chaining next_state->q_addr, episode_done after the 4th, step_cnt=4.
- Epsilon decay (RL_EPS_DECAY_EN): EPS_INIT=16'h0300, EPS_DECAY=16'h0100, EPS_MIN=16'h0180, 3 episodes -> epsilon 0x0200, 0x0180, 0x0180. Without the macro -> 0x0300 throughout.
- Reset mid-UPDATE with upd_ready=0 -> next cycle IDLE, upd_valid=0, step_cnt=0, no episode_done.
